// File: rtl/bip_control.sv
// Instruction-sequencing control for the BIP core: fetches and decodes one
// instruction at a time and drives the accumulator datapath and data-memory strobes.
module bip_control #(
    parameter int ADDRESS_BITS = 11,
    parameter int DATA_BITS    = 16,
    parameter int COUNT_BITS   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [DATA_BITS-1:0]    i_instruction,
    output logic [ADDRESS_BITS-1:0] o_pc,
    output logic [ADDRESS_BITS-1:0] o_operand,
    output logic [1:0]              o_sel_a,
    output logic                    o_sel_b,
    output logic                    o_operation,
    output logic                    o_write_acc,
    output logic                    o_read_mem,
    output logic                    o_write_mem,
    output logic                    o_halted,
    output logic [COUNT_BITS-1:0]   o_cycle_count,
    output logic [2:0]              o_state
);

    localparam int OPC_BITS = DATA_BITS - ADDRESS_BITS;

    localparam logic [OPC_BITS-1:0] OP_HLT  = OPC_BITS'(0);
    localparam logic [OPC_BITS-1:0] OP_STO  = OPC_BITS'(1);
    localparam logic [OPC_BITS-1:0] OP_LD   = OPC_BITS'(2);
    localparam logic [OPC_BITS-1:0] OP_LDI  = OPC_BITS'(3);
    localparam logic [OPC_BITS-1:0] OP_ADD  = OPC_BITS'(4);
    localparam logic [OPC_BITS-1:0] OP_ADDI = OPC_BITS'(5);
    localparam logic [OPC_BITS-1:0] OP_SUB  = OPC_BITS'(6);
    localparam logic [OPC_BITS-1:0] OP_SUBI = OPC_BITS'(7);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDRESS_BITS-1:0] r_pc;
    logic [DATA_BITS-1:0]    r_ir;
    logic [COUNT_BITS-1:0]   r_cycle_count;
    logic [OPC_BITS-1:0]     w_fetch_opc;
    logic [OPC_BITS-1:0]     w_ir_opc;
    logic                    w_active;

    assign w_fetch_opc = i_instruction[DATA_BITS-1:ADDRESS_BITS];
    assign w_ir_opc    = r_ir[DATA_BITS-1:ADDRESS_BITS];
    assign w_active    = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                         (r_state == S_MEM)   || (r_state == S_EXEC);

    assign o_pc          = r_pc;
    assign o_operand     = r_ir[ADDRESS_BITS-1:0];
    assign o_cycle_count = r_cycle_count;
    assign o_state       = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_ir          <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_ir <= i_instruction;
            end
            if (r_state == S_EXEC) begin
                r_pc <= r_pc + ADDRESS_BITS'(1);
            end
            if (w_active && (r_cycle_count != {COUNT_BITS{1'b1}})) begin
                r_cycle_count <= r_cycle_count + COUNT_BITS'(1);
            end
        end
    end

    // Next-state looks at the fetched word; datapath controls only at the latched IR.
    always_comb begin
        w_next      = r_state;
        o_sel_a     = 2'd0;
        o_sel_b     = 1'b0;
        o_operation = 1'b0;
        o_write_acc = 1'b0;
        o_read_mem  = 1'b0;
        o_write_mem = 1'b0;
        o_halted    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_fetch_opc)
                    OP_HLT:                 w_next = S_HALT;
                    OP_LD, OP_ADD, OP_SUB:  w_next = S_MEM;
                    default:                w_next = S_EXEC;
                endcase
            end
            S_MEM: begin
                o_read_mem = 1'b1;
                w_next     = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_ir_opc)
                    OP_STO: o_write_mem = 1'b1;
                    OP_LD: begin
                        o_write_acc = 1'b1;
                        o_sel_a     = 2'd0;
                    end
                    OP_LDI: begin
                        o_write_acc = 1'b1;
                        o_sel_a     = 2'd1;
                    end
                    OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                        o_write_acc = 1'b1;
                        o_sel_a     = 2'd2;
                        o_sel_b     = w_ir_opc[0];
                        o_operation = w_ir_opc[1];
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                o_halted = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control with a synchronous program memory and a small
// accumulator/data-memory model driven by the control strobes.
module tb_bip_control;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_instruction;
    logic [10:0] o_pc;
    logic [10:0] o_operand;
    logic [1:0]  o_sel_a;
    logic        o_sel_b;
    logic        o_operation;
    logic        o_write_acc;
    logic        o_read_mem;
    logic        o_write_mem;
    logic        o_halted;
    logic [15:0] o_cycle_count;
    logic [2:0]  o_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] prog [0:2047];
    logic [15:0] dmem [0:2047];
    logic [15:0] acc;
    logic [15:0] mem_q;
    logic [15:0] st_data;
    logic [10:0] st_addr;
    logic        st_seen;
    logic [15:0] ext_op;
    logic [15:0] alu_b;

    bip_control dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_instruction(i_instruction),
        .o_pc(o_pc), .o_operand(o_operand), .o_sel_a(o_sel_a), .o_sel_b(o_sel_b),
        .o_operation(o_operation), .o_write_acc(o_write_acc), .o_read_mem(o_read_mem),
        .o_write_mem(o_write_mem), .o_halted(o_halted), .o_cycle_count(o_cycle_count),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) i_instruction <= prog[o_pc];

    assign ext_op = {{5{o_operand[10]}}, o_operand};
    assign alu_b  = o_sel_b ? ext_op : mem_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mem_q   <= '0;
            st_seen <= 1'b0;
            st_data <= '0;
            st_addr <= '0;
        end else begin
            if (o_read_mem) mem_q <= dmem[o_operand];
            if (o_write_mem) begin
                st_seen <= 1'b1;
                st_data <= acc;
                st_addr <= o_operand;
            end
            if (o_write_acc) begin
                case (o_sel_a)
                    2'd0:    acc <= mem_q;
                    2'd1:    acc <= ext_op;
                    default: acc <= o_operation ? (acc - alu_b) : (acc + alu_b);
                endcase
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
    endtask

    // Returns at the falling edge of the first FETCH cycle.
    task automatic start_run();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        clear_prog();
        start_run();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({o_pc, o_operand, o_sel_a, o_sel_b, o_operation, o_write_acc, o_read_mem,
             o_write_mem, o_halted, o_cycle_count, o_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: pc=%0h op=%0h halted=%0b cnt=%0d state=%0d, required all zero",
                     o_pc, o_operand, o_halted, o_cycle_count, o_state);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (o_state !== 3'd0 || o_cycle_count !== 16'd0) begin
            n_fail++;
            $display("FAIL idle_hold: state=%0d cnt=%0d, required state=0 cnt=0", o_state, o_cycle_count);
        end
    endtask

    task automatic test_program();
        do_reset();
        clear_prog();
        prog[0] = 16'h1805;  // LDI 5
        prog[1] = 16'h2803;  // ADDI 3
        prog[2] = 16'h3801;  // SUBI 1
        prog[3] = 16'h0000;  // HLT
        start_run();
        repeat (10) @(negedge clk);
        n_checks++;
        if (o_halted !== 1'b0) begin
            n_fail++;
            $display("FAIL prog_not_yet_halted: halted=%0b, required 0 at cycle 11", o_halted);
        end
        @(negedge clk);
        n_checks++;
        if (o_halted !== 1'b1 || o_state !== 3'd5) begin
            n_fail++;
            $display("FAIL prog_halted: halted=%0b state=%0d, required 1/5", o_halted, o_state);
        end
        n_checks++;
        if (o_cycle_count !== 16'd11) begin
            n_fail++;
            $display("FAIL prog_count: got %0d, required 11", o_cycle_count);
        end
        n_checks++;
        if (o_pc !== 11'd3) begin
            n_fail++;
            $display("FAIL prog_pc: got %0d, required 3", o_pc);
        end
        n_checks++;
        if (acc !== 16'd7) begin
            n_fail++;
            $display("FAIL prog_acc: got %0h, required 7", acc);
        end
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_halted !== 1'b1 || o_pc !== 11'd3 || o_cycle_count !== 16'd11) begin
            n_fail++;
            $display("FAIL halt_sticky: halted=%0b pc=%0d cnt=%0d, required 1/3/11",
                     o_halted, o_pc, o_cycle_count);
        end
    endtask

    task automatic test_ld();
        do_reset();
        clear_prog();
        prog[0]  = 16'h100A;  // LD 10
        dmem[10] = 16'h1234;
        start_run();
        n_checks++;
        if (o_read_mem !== 1'b0 || o_state !== 3'd1) begin
            n_fail++;
            $display("FAIL ld_fetch: rd=%0b state=%0d, required 0/1", o_read_mem, o_state);
        end
        @(negedge clk);
        n_checks++;
        if (o_read_mem !== 1'b0 || o_write_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_decode: rd=%0b wa=%0b, required 0/0", o_read_mem, o_write_acc);
        end
        @(negedge clk);
        n_checks++;
        if (o_read_mem !== 1'b1 || o_write_acc !== 1'b0 || o_operand !== 11'd10) begin
            n_fail++;
            $display("FAIL ld_mem: rd=%0b wa=%0b op=%0d, required 1/0/10", o_read_mem, o_write_acc, o_operand);
        end
        @(negedge clk);
        n_checks++;
        if (o_read_mem !== 1'b0 || o_write_acc !== 1'b1 || o_sel_a !== 2'd0 || o_operand !== 11'd10) begin
            n_fail++;
            $display("FAIL ld_exec: rd=%0b wa=%0b sa=%0d op=%0d, required 0/1/0/10",
                     o_read_mem, o_write_acc, o_sel_a, o_operand);
        end
        @(negedge clk);
        n_checks++;
        if (acc !== 16'h1234 || o_pc !== 11'd1) begin
            n_fail++;
            $display("FAIL ld_result: acc=%0h pc=%0d, required 1234/1", acc, o_pc);
        end
    endtask

    task automatic test_sto();
        do_reset();
        clear_prog();
        prog[0] = 16'h1FFF;  // LDI -1
        prog[1] = 16'h0814;  // STO 20
        start_run();
        repeat (5) @(negedge clk);
        n_checks++;
        if (o_write_mem !== 1'b1 || o_operand !== 11'd20 || o_write_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL sto_exec: wm=%0b op=%0d wa=%0b, required 1/20/0", o_write_mem, o_operand, o_write_acc);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (st_seen !== 1'b1 || st_addr !== 11'd20 || st_data !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sto_data: seen=%0b addr=%0d data=%0h, required 1/20/ffff", st_seen, st_addr, st_data);
        end
        n_checks++;
        if (o_halted !== 1'b1 || o_pc !== 11'd2) begin
            n_fail++;
            $display("FAIL sto_halt: halted=%0b pc=%0d, required 1/2", o_halted, o_pc);
        end
    endtask

    task automatic test_nop();
        do_reset();
        clear_prog();
        prog[0] = 16'hF800;  // opcode 11111
        start_run();
        repeat (2) @(negedge clk);
        n_checks++;
        if (o_state !== 3'd4 || {o_write_acc, o_read_mem, o_write_mem, o_sel_a, o_sel_b, o_operation} !== '0) begin
            n_fail++;
            $display("FAIL nop_exec: state=%0d wa=%0b rd=%0b wm=%0b sa=%0d, required 4 with no strobes",
                     o_state, o_write_acc, o_read_mem, o_write_mem, o_sel_a);
        end
        @(negedge clk);
        n_checks++;
        if (o_pc !== 11'd1 || o_state !== 3'd1) begin
            n_fail++;
            $display("FAIL nop_advance: pc=%0d state=%0d, required 1/1", o_pc, o_state);
        end
        repeat (2) @(negedge clk);
        i_start = 1'b1;
        repeat (2) @(negedge clk);
        i_start = 1'b0;
        n_checks++;
        if (o_halted !== 1'b1 || o_pc !== 11'd1 || o_cycle_count !== 16'd5) begin
            n_fail++;
            $display("FAIL nop_halt: halted=%0b pc=%0d cnt=%0d, required 1/1/5", o_halted, o_pc, o_cycle_count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        clear_prog();
        prog[0] = 16'h2004;  // ADD 4
        start_run();
        repeat (2) @(negedge clk);
        n_checks++;
        if (o_read_mem !== 1'b1) begin
            n_fail++;
            $display("FAIL add_mem: rd=%0b, required 1", o_read_mem);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (o_read_mem !== 1'b0 || o_state !== 3'd0 || o_operand !== 11'd0 || o_write_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: rd=%0b state=%0d op=%0d wa=%0b, required 0/0/0/0",
                     o_read_mem, o_state, o_operand, o_write_acc);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_state !== 3'd0 || o_cycle_count !== 16'd0 || o_write_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: state=%0d cnt=%0d wa=%0b, required 0/0/0", o_state, o_cycle_count, o_write_acc);
        end
        start_run();
        n_checks++;
        if (o_state !== 3'd1 || o_pc !== 11'd0) begin
            n_fail++;
            $display("FAIL restart: state=%0d pc=%0d, required 1/0", o_state, o_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 2048; i++) prog[i] = 16'hF800;
        start_run();
        repeat (6141) @(negedge clk);
        n_checks++;
        if (o_pc !== 11'h7FF || o_state !== 3'd1) begin
            n_fail++;
            $display("FAIL wrap_last: pc=%0h state=%0d, required 7ff/1", o_pc, o_state);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_pc !== 11'd0 || o_state !== 3'd1 || o_cycle_count !== 16'd6144) begin
            n_fail++;
            $display("FAIL wrap_zero: pc=%0h state=%0d cnt=%0d, required 0/1/6144", o_pc, o_state, o_cycle_count);
        end
        do_reset();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) dmem[i] = 16'h0000;
        clear_prog();
        rst = 1'b1;
        #1;
        n_checks++;
        if (o_state !== 3'd0 || o_pc !== 11'd0 || o_halted !== 1'b0) begin
            n_fail++;
            $display("FAIL power_on_reset: state=%0d pc=%0d halted=%0b, required 0/0/0", o_state, o_pc, o_halted);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_program();
        test_ld();
        test_sto();
        test_nop();
        test_mid_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
